// File: rtl/led_seq_pkg.sv
// Shared types and width helpers for the timed LED sequencer and its prescaler.
package led_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ON   = 4'b0010,
    S_OFF  = 4'b0100,
    S_REST = 4'b1000
  } state_t;

  // Width of an index/counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int runs_width(input int runs_max);
    return $clog2(runs_max + 1);
  endfunction

  function automatic int dbg_width(input int timer_w, input int runs_max, input int num_ch);
    return timer_w + runs_width(runs_max) + num_ch + 4;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; tick is high for the one cycle where the count is zero.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter  int DIV  = 65536,
  localparam int PC_W = cnt_width(DIV)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick,
  output logic [PC_W-1:0] pcount
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst)                              pcount <= '0;
    else if (pcount == PC_W'(DIV - 1))    pcount <= '0;
    else                                  pcount <= pcount + PC_W'(1);
  end

  assign tick = (pcount == '0);

endmodule

// File: rtl/led_seq_timer.sv
// Timed ON/OFF/REST LED sequencer: walks a lit channel across NUM_CH outputs in bursts of RUNS_MAX runs.
module led_seq_timer
  import led_seq_pkg::*;
#(
  parameter  int NUM_CH       = 3,
  parameter  int PRESCALE_DIV = 65536,
  parameter  int TIMER_W      = 8,
  parameter  int ON_TICKS     = 100,
  parameter  int OFF_TICKS    = 250,
  parameter  int REST_TICKS   = 250,
  parameter  int RUNS_MAX     = 10,
  localparam int RUNS_W       = runs_width(RUNS_MAX),
  localparam int DBG_W        = dbg_width(TIMER_W, RUNS_MAX, NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              walk_i,
  input  logic              oneshot_i,
  output logic [NUM_CH-1:0] led_o,
  output logic              tick_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [DBG_W-1:0]  dbg_o
);

  localparam int CH_W = cnt_width(NUM_CH);
  localparam int PC_W = cnt_width(PRESCALE_DIV);

  localparam logic [TIMER_W-1:0] ON_T     = TIMER_W'(ON_TICKS);
  localparam logic [TIMER_W-1:0] OFF_T    = TIMER_W'(OFF_TICKS);
  localparam logic [TIMER_W-1:0] REST_T   = TIMER_W'(REST_TICKS);
  localparam logic [RUNS_W-1:0]  RUNS_TOP = RUNS_W'(RUNS_MAX);
  localparam logic [NUM_CH-1:0]  LED_ONE  = NUM_CH'(1);

  if (ON_TICKS >= (1 << TIMER_W) || OFF_TICKS >= (1 << TIMER_W) ||
      REST_TICKS >= (1 << TIMER_W)) begin : g_bad_ticks
    $error("led_seq_timer: *_TICKS must fit in TIMER_W bits");
  end
  if (NUM_CH < 1 || PRESCALE_DIV < 1 || ON_TICKS < 1 || OFF_TICKS < 1 ||
      REST_TICKS < 1 || RUNS_MAX < 1) begin : g_bad_params
    $error("led_seq_timer: all sizing parameters must be >= 1");
  end

  logic              tick;
  logic [PC_W-1:0]   pcount;
  logic              unused_pcount;

  state_t            state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [CH_W-1:0]   chan_q, chan_d, chan_walk;
  logic [NUM_CH-1:0] led_d;
  logic              done_d;
  logic              timer_zero;

  tick_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .pcount (pcount)
  );

  assign unused_pcount = ^pcount;
  assign timer_zero    = (timer_q == '0);
  assign chan_walk     = !walk_i                       ? chan_q :
                         (chan_q == CH_W'(NUM_CH - 1)) ? '0     : chan_q + CH_W'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = (!timer_zero && tick) ? timer_q - TIMER_W'(1) : timer_q;
    runs_d  = runs_q;
    chan_d  = chan_q;
    led_d   = led_o;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (en_i) begin
        state_d = S_ON;
        timer_d = ON_T;
        led_d   = LED_ONE << chan_q;
      end
      S_ON: if (timer_zero) begin
        state_d = S_OFF;
        timer_d = OFF_T;
        runs_d  = runs_q + RUNS_W'(1);
        led_d   = '0;
      end
      S_OFF: if (timer_zero) begin
        if (!en_i) begin
          state_d = S_IDLE;
          runs_d  = '0;
          chan_d  = '0;
        end else if (runs_q == RUNS_TOP) begin
          state_d = S_REST;
          timer_d = REST_T;
          done_d  = 1'b1;
        end else begin
          state_d = S_ON;
          timer_d = ON_T;
          chan_d  = chan_walk;
          led_d   = LED_ONE << chan_walk;
        end
      end
      S_REST: if (timer_zero) begin
        runs_d = '0;
        chan_d = '0;
        if (!en_i || oneshot_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ON;
          timer_d = ON_T;
          led_d   = LED_ONE;
        end
      end
      // Corrupted encodings recover through IDLE with the LEDs dark.
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      runs_q  <= '0;
      chan_q  <= '0;
      led_o   <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      runs_q  <= runs_d;
      chan_q  <= chan_d;
      led_o   <= led_d;
      done_o  <= done_d;
    end
  end

  assign tick_o = tick;
  assign busy_o = (state_q != S_IDLE);
  assign dbg_o  = {timer_q, runs_q, led_o, state_q};

endmodule

// File: tb/tb_led_seq_timer.sv
// Directed bench for led_seq_timer: main build plus NUM_CH=1 and PRESCALE_DIV=1 variants on shared stimulus.
module tb_led_seq_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic walk = 1'b0;
  logic oneshot = 1'b0;

  logic [2:0]  led;
  logic        tick, done, busy;
  logic [12:0] dbg;

  logic [0:0]  led1;
  logic        tick1, done1, busy1;
  logic [10:0] dbg1;

  logic [2:0]  led2;
  logic        tick2, done2, busy2;
  logic [12:0] dbg2;

  int errors = 0;
  int checks = 0;
  int ed = 0;

  always #5 clk = ~clk;

  led_seq_timer #(
    .NUM_CH(3), .PRESCALE_DIV(4), .TIMER_W(4), .ON_TICKS(2), .OFF_TICKS(3),
    .REST_TICKS(1), .RUNS_MAX(2)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .walk_i(walk), .oneshot_i(oneshot),
    .led_o(led), .tick_o(tick), .done_o(done), .busy_o(busy), .dbg_o(dbg)
  );

  led_seq_timer #(
    .NUM_CH(1), .PRESCALE_DIV(4), .TIMER_W(4), .ON_TICKS(2), .OFF_TICKS(3),
    .REST_TICKS(1), .RUNS_MAX(2)
  ) dut_one_ch (
    .clk(clk), .rst(rst), .en_i(en), .walk_i(walk), .oneshot_i(oneshot),
    .led_o(led1), .tick_o(tick1), .done_o(done1), .busy_o(busy1), .dbg_o(dbg1)
  );

  led_seq_timer #(
    .NUM_CH(3), .PRESCALE_DIV(1), .TIMER_W(4), .ON_TICKS(2), .OFF_TICKS(3),
    .REST_TICKS(1), .RUNS_MAX(2)
  ) dut_div1 (
    .clk(clk), .rst(rst), .en_i(en), .walk_i(walk), .oneshot_i(oneshot),
    .led_o(led2), .tick_o(tick2), .done_o(done2), .busy_o(busy2), .dbg_o(dbg2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to rising edge n after reset release, then sample 1 time unit later.
  task automatic goto(input int n);
    repeat (n - ed) @(posedge clk);
    ed = n;
    #1;
  endtask

  task automatic restart(input logic e, input logic w, input logic o);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    en = e;
    walk = w;
    oneshot = o;
    rst = 1'b0;
    ed = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_dbg", dbg, 13'b0000_00_000_0001);
    check("reset_led", led, 3'b000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_tick", tick, 1'b1);

    // Full burst, walking, repeating
    restart(1'b1, 1'b1, 1'b0);
    goto(1);
    check("b1_e1_state", dbg[3:0], 4'b0010);
    check("b1_e1_led", led, 3'b001);
    check("b1_e1_busy", busy, 1'b1);
    check("ch1_e1_led", led1, 1'b1);
    check("div1_e1_led", led2, 3'b001);
    goto(3);
    check("div1_e3_state", dbg2[3:0], 4'b0010);
    check("div1_e3_led", led2, 3'b001);
    goto(4);
    check("div1_e4_state", dbg2[3:0], 4'b0100);
    check("div1_e4_led", led2, 3'b000);
    check("div1_tick", tick2, 1'b1);
    check("b1_e4_tick", tick, 1'b1);
    check("b1_e4_dbg", dbg, {4'd2, 2'd0, 3'b001, 4'b0010});
    goto(5);
    check("b1_e5_tick", tick, 1'b0);
    check("div1_e5_tick", tick2, 1'b1);
    goto(9);
    check("b1_e9_led", led, 3'b001);
    check("b1_e9_state", dbg[3:0], 4'b0010);
    goto(10);
    check("b1_e10_dbg", dbg, {4'd3, 2'd1, 3'b000, 4'b0100});
    check("ch1_e10_led", led1, 1'b0);
    goto(22);
    check("b1_e22_led", led, 3'b010);
    check("b1_e22_state", dbg[3:0], 4'b0010);
    check("ch1_e22_led", led1, 1'b1);
    goto(41);
    check("b1_e41_state", dbg[3:0], 4'b0100);
    check("b1_e41_done", done, 1'b0);
    goto(42);
    check("b1_e42_done", done, 1'b1);
    check("b1_e42_dbg", dbg, {4'd1, 2'd2, 3'b000, 4'b1000});
    goto(43);
    check("b1_e43_done", done, 1'b0);
    goto(46);
    check("b1_e46_dbg", dbg, {4'd2, 2'd0, 3'b001, 4'b0010});
    check("ch1_e46_led", led1, 1'b1);

    // One-shot burst returns to IDLE, then re-enters ON because en stays high
    restart(1'b1, 1'b1, 1'b1);
    goto(42);
    check("os_e42_done", done, 1'b1);
    goto(46);
    check("os_e46_dbg", dbg, 13'b0000_00_000_0001);
    check("os_e46_busy", busy, 1'b0);
    check("os_e46_done", done, 1'b0);
    goto(47);
    check("os_e47_state", dbg[3:0], 4'b0010);
    check("os_e47_led", led, 3'b001);
    check("os_e47_done", done, 1'b0);

    // walk_i=0 keeps the same channel
    restart(1'b1, 1'b0, 1'b0);
    goto(1);
    check("nw_e1_led", led, 3'b001);
    goto(22);
    check("nw_e22_led", led, 3'b001);
    goto(30);
    check("nw_e30_led", led, 3'b000);

    // en dropped mid second ON: run completes, disable beats the REST branch
    restart(1'b1, 1'b1, 1'b0);
    goto(25);
    en = 1'b0;
    goto(30);
    check("dis_e30_state", dbg[3:0], 4'b0100);
    check("dis_e30_runs", dbg[8:7], 2'd2);
    goto(41);
    check("dis_e41_state", dbg[3:0], 4'b0100);
    goto(42);
    check("dis_e42_dbg", dbg, 13'b0000_00_000_0001);
    check("dis_e42_done", done, 1'b0);
    en = 1'b1;
    goto(43);
    check("dis_e43_led", led, 3'b001);

    // Reset pulsed mid-OFF
    restart(1'b1, 1'b1, 1'b0);
    goto(15);
    check("rst_e15_state", dbg[3:0], 4'b0100);
    rst = 1'b1;
    goto(16);
    check("rst_e16_dbg", dbg, 13'b0000_00_000_0001);
    check("rst_e16_led", led, 3'b000);
    check("rst_e16_busy", busy, 1'b0);
    check("rst_e16_tick", tick, 1'b1);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
